lcd_bus_sequencer: RTL and testbench
====================================

Name: lcd_bus_sequencer

Overview:
Avalon-MM slave that sequences 8080-style parallel LCD bus cycles (CS/RS/WR/RD strobes plus a 16-bit bidirectional data bus) in hardware. It replaces software bit-banging of the LCD through the 16-bit bidirectional PIO. The CPU queues command, data and read operations into a small FIFO. The block executes them with programmable setup, pulse and hold timing.

Parameters:
FIFO_DEPTH, 8, operation FIFO entries; power of 2, 2..64
T_SETUP, 1, cycles CS/RS/data stable before strobe falls; 0 = skip phase
T_PULSE, 3, WR strobe low width in cycles; must be >= 1
T_RD_PULSE, 5, RD strobe low width in cycles; must be >= 1
T_HOLD, 1, cycles CS/RS/data held after strobe rises; 0 = skip phase

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  Avalon register select
chipselect  in  1  Avalon chip select
write_n  in  1  Avalon write strobe, active low
read_n  in  1  Avalon read strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered, 1-cycle latency
lcd_data  inout  16  LCD data bus
lcd_cs_n  out  1  LCD chip select, active low
lcd_rs  out  1  register select: 0 = command, 1 = data
lcd_wr_n  out  1  write strobe, active low
lcd_rd_n  out  1  read strobe, active low

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk.
- Reset values: readdata=0, lcd_cs_n=1, lcd_rs=0, lcd_wr_n=1, lcd_rd_n=1, lcd_data=Z. FIFO is emptied, state=IDLE, rd_data=0, rd_valid=0, overflow=0.
- Register map (writes require chipselect && !write_n):
  - addr0 write: push {WR, rs=0, writedata[15:0]}.
  - addr1 write: push {WR, rs=1, writedata[15:0]}.
  - addr2 read: status. bit0 busy (FIFO non-empty or state!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bit4 rd_valid. bits[15:8] = FIFO count; other bits 0.
  - addr2 write: writedata[3]=1 clears overflow.
  - addr3 write: push {RD, rs=writedata[16]}.
  - addr3 read: returns {16'b0, rd_data}; clears rd_valid on the cycle the read is accepted.
  - addr0/addr1 reads return 0.
- A push when the FIFO is full is dropped and sets overflow; FIFO contents are unchanged.
- Simultaneous push and pop in one cycle: both occur; count is unchanged. A pop never occurs when the FIFO is empty.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if FIFO non-empty, pop the head into the op register, load the counter, go to SETUP. If T_SETUP=0, go directly to STROBE.
  - SETUP: lasts T_SETUP cycles, then STROBE.
  - STROBE: lasts T_PULSE cycles (WR op) or T_RD_PULSE cycles (RD op). On its final cycle, an RD op captures lcd_data into rd_data and sets rd_valid. Then go to HOLD, or IDLE if T_HOLD=0.
  - HOLD: lasts T_HOLD cycles, then IDLE.
- LCD outputs are decoded only from registered state and the op register; there is no combinational path from Avalon inputs.
  - lcd_cs_n=0 and lcd_rs=op.rs in SETUP, STROBE and HOLD.
  - lcd_wr_n=0 only in STROBE for WR ops; lcd_rd_n=0 only in STROBE for RD ops.
  - lcd_data is driven with op.data in SETUP/STROBE/HOLD of WR ops, and is Z at all other times.
- IDLE always lasts at least 1 cycle between operations, so lcd_cs_n rises between back-to-back ops. Default WR op period is 6 cycles; default RD op period is 8 cycles.
- Latency: an Avalon push at edge N drives lcd_cs_n low after edge N+2 when the FSM was idle.
- The counter is 8 bits; timing parameter values above 255 are illegal.
- A new RD completion overwrites rd_data even when rd_valid is already 1; no error is flagged.
- reset_n asserted mid-operation immediately returns all LCD outputs to their reset values (strobes high, bus Z). The in-flight op and all queued ops are discarded.

Test Plan:
- Write 0x2C to addr0 -> one cycle: lcd_cs_n low 5 cycles, lcd_rs=0, lcd_wr_n low on cycles 2-4, lcd_data=0x002C throughout, Z before and after.
- Write 0x1234, 0x5678, 0x9ABC to addr1 back-to-back -> three WR cycles with rs=1 in order. lcd_cs_n is high for exactly 1 cycle between them. Status count reads 2 immediately after the third push, and busy=0 after 18 cycles.
- Write addr3 with bit16=1 while the bench drives lcd_data=0xBEEF during RD pulse -> lcd_rd_n low 5 cycles, lcd_data undriven by DUT. Status bit4=1; addr3 read returns 0x0000BEEF; a subsequent status read shows bit4=0.
- Issue 9 pushes with FIFO_DEPTH=8 while the FSM is stalled in a long op -> 9th push is dropped and overflow=1. Writing addr2 with 0x8 clears overflow; exactly 9 LCD cycles occur in total (1 in flight + 8 queued).
- Assert reset_n during STROBE of a WR op with 3 ops queued -> same cycle: lcd_wr_n=1, lcd_cs_n=1, bus Z. After release, status shows empty=1, busy=0, and no further LCD activity.
- Build with T_SETUP=0, T_HOLD=0 -> lcd_wr_n falls in the same cycle as lcd_cs_n, and both rise together after T_PULSE cycles.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave that queues 8080-style LCD write/read cycles and plays them
// out on the parallel bus with programmable setup, pulse and hold timing.
module lcd_bus_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned T_SETUP    = 1,
  parameter int unsigned T_PULSE    = 3,
  parameter int unsigned T_RD_PULSE = 5,
  parameter int unsigned T_HOLD     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  inout  wire  [15:0] lcd_data,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 8;

  localparam logic [TW-1:0] SETUP_LD = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] WR_LD    = TW'(T_PULSE - 1);
  localparam logic [TW-1:0] RD_LD    = TW'(T_RD_PULSE - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(T_HOLD - 1);

  typedef struct packed {
    logic          is_rd;
    logic          rs;
    logic [DW-1:0] data;
  } op_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  op_t           op, op_nxt, push_op, head;
  op_t           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_acc, rd_acc, push_req, push, pop, capture;
  logic          full, empty, busy;
  logic          overflow, rd_valid;
  logic [DW-1:0] rd_data;
  logic          data_oe;
  logic [DW-1:0] data_out;
  logic [31:0]   status;
  logic          unused_wd;

  assign wr_acc    = chipselect && !write_n;
  assign rd_acc    = chipselect && !read_n;
  assign push_req  = wr_acc && (address != 2'd2);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = push_req && !full;
  assign busy      = !empty || (state != IDLE);
  assign head      = fifo_mem[rd_ptr];
  assign unused_wd = ^writedata[31:17];

  always_comb begin
    push_op       = '0;
    push_op.is_rd = (address == 2'd3);
    push_op.rs    = (address == 2'd3) ? writedata[16] : address[0];
    push_op.data  = writedata[DW-1:0];
  end

  // Operation FIFO storage; no reset needed, validity tracked by count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_op;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
    end
  end

  // Phase sequencing; zero-length setup/hold phases are skipped entirely.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          op_nxt = head;
          if (T_SETUP != 0) begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
          end else begin
            state_nxt = STROBE;
            cnt_nxt   = head.is_rd ? RD_LD : WR_LD;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = op.is_rd ? RD_LD : WR_LD;
        end else begin
          cnt_nxt = cnt - TW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          capture = op.is_rd;
          if (T_HOLD != 0) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - TW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // LCD pins decoded from registered state only, so nothing leaks from Avalon.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_cs_n <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_wr_n <= 1'b1;
      lcd_rd_n <= 1'b1;
      data_oe  <= 1'b0;
      data_out <= '0;
    end else begin
      lcd_cs_n <= (state == IDLE);
      lcd_rs   <= (state != IDLE) && op.rs;
      lcd_wr_n <= !((state == STROBE) && !op.is_rd);
      lcd_rd_n <= !((state == STROBE) && op.is_rd);
      data_oe  <= (state != IDLE) && !op.is_rd;
      data_out <= op.data;
    end
  end

  assign lcd_data = data_oe ? data_out : {DW{1'bz}};

  assign status = {16'b0, 8'(count), 3'b0, rd_valid, overflow, empty, full, busy};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_req && full)                                overflow <= 1'b1;
      else if (wr_acc && (address == 2'd2) && writedata[3]) overflow <= 1'b0;

      // A fresh capture wins over a same-cycle read clear.
      if (capture) begin
        rd_data  <= lcd_data;
        rd_valid <= 1'b1;
      end else if (rd_acc && (address == 2'd3)) begin
        rd_valid <= 1'b0;
      end

      readdata <= '0;
      if (rd_acc) begin
        case (address)
          2'd2:    readdata <= status;
          2'd3:    readdata <= {16'b0, rd_data};
          default: readdata <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench: default-timing instance (a) and a zero setup/hold, long
// pulse instance (b) used for overflow and strobe-alignment scenarios.
module tb_lcd_bus_sequencer;
  localparam int unsigned B_PULSE = 20;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [1:0]  addr_a, addr_b;
  logic        csel_a, csel_b, wn_a, wn_b, rn_a, rn_b;
  logic [31:0] wd_a, wd_b, rdata_a, rdata_b;
  wire  [15:0] lcd_data_a, lcd_data_b;
  logic        cs_n_a, rs_a, wr_n_a, rd_n_a;
  logic        cs_n_b, rs_b, wr_n_b, rd_n_b;
  logic        lcd_drive_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // LCD panel model: returns 0xBEEF while its read strobe is low.
  assign lcd_data_a = (lcd_drive_en && !rd_n_a) ? 16'hBEEF : 16'hzzzz;

  lcd_bus_sequencer dut_a (
    .clk(clk), .reset_n(rst_a), .address(addr_a), .chipselect(csel_a),
    .write_n(wn_a), .read_n(rn_a), .writedata(wd_a), .readdata(rdata_a),
    .lcd_data(lcd_data_a), .lcd_cs_n(cs_n_a), .lcd_rs(rs_a),
    .lcd_wr_n(wr_n_a), .lcd_rd_n(rd_n_a)
  );

  lcd_bus_sequencer #(.T_SETUP(0), .T_PULSE(B_PULSE), .T_HOLD(0)) dut_b (
    .clk(clk), .reset_n(rst_b), .address(addr_b), .chipselect(csel_b),
    .write_n(wn_b), .read_n(rn_b), .writedata(wd_b), .readdata(rdata_b),
    .lcd_data(lcd_data_b), .lcd_cs_n(cs_n_b), .lcd_rs(rs_b),
    .lcd_wr_n(wr_n_b), .lcd_rd_n(rd_n_b)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        data_z;
    logic        rs;
    logic        wr_at_fall;
    logic [7:0]  gap;
    logic [7:0]  cs_len;
    logic [7:0]  wr_len;
    logic [7:0]  rd_len;
  } op_rec_t;

  op_rec_t recs [2][16];
  int      n_ops [2];
  int      gap_c [2];
  int      cs_len [2];
  int      wr_len [2];
  int      rd_len [2];
  logic    prev_cs [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
    if (!sel) begin addr_a = a; wd_a = d; csel_a = 1'b1; wn_a = 1'b0; end
    else      begin addr_b = a; wd_b = d; csel_b = 1'b1; wn_b = 1'b0; end
    @(posedge clk); #1;
    csel_a = 1'b0; wn_a = 1'b1; csel_b = 1'b0; wn_b = 1'b1;
  endtask

  task automatic bus_read(input bit sel, input logic [1:0] a, output logic [31:0] d);
    if (!sel) begin addr_a = a; csel_a = 1'b1; rn_a = 1'b0; end
    else      begin addr_b = a; csel_b = 1'b1; rn_b = 1'b0; end
    @(posedge clk); #1;
    d = sel ? rdata_b : rdata_a;
    csel_a = 1'b0; rn_a = 1'b1; csel_b = 1'b0; rn_b = 1'b1;
  endtask

  // Per-operation bus monitor, sampled on the falling clock edge.
  always @(negedge clk) begin : mon
    logic cs, wr, rd, rs, dz;
    logic [15:0] dv;
    for (int k = 0; k < 2; k++) begin
      cs = (k == 0) ? cs_n_a : cs_n_b;
      wr = (k == 0) ? wr_n_a : wr_n_b;
      rd = (k == 0) ? rd_n_a : rd_n_b;
      rs = (k == 0) ? rs_a : rs_b;
      dv = (k == 0) ? lcd_data_a : lcd_data_b;
      dz = (k == 0) ? (lcd_data_a === 16'hzzzz) : (lcd_data_b === 16'hzzzz);
      if (cs) begin
        if (!prev_cs[k]) begin
          if (n_ops[k] > 0 && n_ops[k] <= 16) begin
            recs[k][n_ops[k]-1].cs_len = 8'(cs_len[k]);
            recs[k][n_ops[k]-1].wr_len = 8'(wr_len[k]);
            recs[k][n_ops[k]-1].rd_len = 8'(rd_len[k]);
          end
          gap_c[k] = 1;
        end else begin
          gap_c[k] = gap_c[k] + 1;
        end
      end else begin
        if (prev_cs[k]) begin
          if (n_ops[k] < 16) begin
            recs[k][n_ops[k]].gap        = 8'(gap_c[k]);
            recs[k][n_ops[k]].data       = dv;
            recs[k][n_ops[k]].data_z     = dz;
            recs[k][n_ops[k]].rs         = rs;
            recs[k][n_ops[k]].wr_at_fall = wr;
          end
          n_ops[k]  = n_ops[k] + 1;
          cs_len[k] = 0;
          wr_len[k] = 0;
          rd_len[k] = 0;
        end
        cs_len[k] = cs_len[k] + 1;
        if (!wr) wr_len[k] = wr_len[k] + 1;
        if (!rd) rd_len[k] = rd_len[k] + 1;
      end
      prev_cs[k] = cs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  cs_tr, wr_tr;
    logic [15:0] dat_mid;
    logic        rs_mid, z_pre, z_post;
    int          ops_before;

    for (int k = 0; k < 2; k++) begin
      n_ops[k] = 0; gap_c[k] = 0; cs_len[k] = 0; wr_len[k] = 0; rd_len[k] = 0;
      prev_cs[k] = 1'b1;
    end
    rst_a = 1'b0; rst_b = 1'b0; lcd_drive_en = 1'b0;
    addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
    csel_a = 1'b0; csel_b = 1'b0; wn_a = 1'b1; wn_b = 1'b1; rn_a = 1'b1; rn_b = 1'b1;

    // Reset values
    repeat (2) @(posedge clk); #1;
    check("rst_cs_n", 32'(cs_n_a), 32'd1);
    check("rst_rs", 32'(rs_a), 32'd0);
    check("rst_wr_n", 32'(wr_n_a), 32'd1);
    check("rst_rd_n", 32'(rd_n_a), 32'd1);
    check("rst_bus_z", 32'(lcd_data_a === 16'hzzzz), 32'd1);
    check("rst_readdata", rdata_a, 32'd0);
    @(negedge clk); rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;
    bus_read(0, 2'd2, d);
    check("rst_status", d, 32'h0000_0004);

    // Single command write: cs low 5 cycles, wr low on cycles 2-4
    bus_write(0, 2'd0, 32'h0000_002C);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cs_tr[i] = cs_n_a;
      wr_tr[i] = wr_n_a;
      if (i == 0) z_pre = (lcd_data_a === 16'hzzzz);
      if (i == 3) begin dat_mid = lcd_data_a; rs_mid = rs_a; end
      if (i == 6) z_post = (lcd_data_a === 16'hzzzz);
    end
    check("cmd_cs_trace", 32'(cs_tr), 32'h0000_00C1);
    check("cmd_wr_trace", 32'(wr_tr), 32'h0000_00E3);
    check("cmd_bus_z_before", 32'(z_pre), 32'd1);
    check("cmd_bus_z_after", 32'(z_post), 32'd1);
    check("cmd_data_strobe", 32'(dat_mid), 32'h0000_002C);
    check("cmd_rs", 32'(rs_mid), 32'd0);
    check("cmd_data_setup", 32'(recs[0][0].data), 32'h0000_002C);

    // Three back-to-back data writes
    bus_write(0, 2'd1, 32'h0000_1234);
    bus_write(0, 2'd1, 32'h0000_5678);
    bus_write(0, 2'd1, 32'h0000_9ABC);
    bus_read(0, 2'd2, d);
    check("burst_status_count2", d, 32'h0000_0201);
    repeat (14) @(posedge clk); #1;
    bus_read(0, 2'd2, d);
    check("burst_busy_at_17", d, 32'h0000_0005);
    bus_read(0, 2'd2, d);
    check("burst_idle_at_18", d, 32'h0000_0004);
    check("burst_d0", 32'(recs[0][1].data), 32'h0000_1234);
    check("burst_d1", 32'(recs[0][2].data), 32'h0000_5678);
    check("burst_d2", 32'(recs[0][3].data), 32'h0000_9ABC);
    check("burst_rs", 32'({recs[0][1].rs, recs[0][2].rs, recs[0][3].rs}), 32'd7);
    check("burst_gap1", 32'(recs[0][2].gap), 32'd1);
    check("burst_gap2", 32'(recs[0][3].gap), 32'd1);
    check("burst_cs_len", 32'(recs[0][1].cs_len), 32'd5);

    // Data read: panel drives 0xBEEF while rd_n is low
    lcd_drive_en = 1'b1;
    bus_write(0, 2'd3, 32'h0001_4100);
    repeat (10) @(posedge clk); #1;
    bus_read(0, 2'd2, d);
    check("rd_status_valid", d, 32'h0000_0014);
    bus_read(0, 2'd3, d);
    check("rd_data", d, 32'h0000_BEEF);
    bus_read(0, 2'd2, d);
    check("rd_valid_cleared", d, 32'h0000_0004);
    lcd_drive_en = 1'b0;
    check("rd_op_count", 32'(n_ops[0]), 32'd5);
    check("rd_cs_len", 32'(recs[0][4].cs_len), 32'd7);
    check("rd_rd_len", 32'(recs[0][4].rd_len), 32'd5);
    check("rd_wr_len", 32'(recs[0][4].wr_len), 32'd0);
    check("rd_rs", 32'(recs[0][4].rs), 32'd1);
    check("rd_bus_undriven", 32'(recs[0][4].data_z), 32'd1);
    check("burst_last_cs_len", 32'(recs[0][3].cs_len), 32'd5);

    // Reset during a write strobe with three ops queued
    bus_write(0, 2'd0, 32'h0000_0011);
    bus_write(0, 2'd0, 32'h0000_0022);
    bus_write(0, 2'd0, 32'h0000_0033);
    bus_write(0, 2'd0, 32'h0000_0044);
    check("pre_rst_wr_low", 32'(wr_n_a), 32'd0);
    #2 rst_a = 1'b0;
    #1;
    check("mid_rst_wr_n", 32'(wr_n_a), 32'd1);
    check("mid_rst_cs_n", 32'(cs_n_a), 32'd1);
    check("mid_rst_bus_z", 32'(lcd_data_a === 16'hzzzz), 32'd1);
    ops_before = n_ops[0];
    @(negedge clk); rst_a = 1'b1;
    @(posedge clk); #1;
    bus_read(0, 2'd2, d);
    check("post_rst_status", d, 32'h0000_0004);
    repeat (20) @(posedge clk); #1;
    check("post_rst_no_ops", 32'(n_ops[0]), 32'(ops_before));
    check("post_rst_cs_idle", 32'(cs_n_a), 32'd1);

    // Zero setup/hold instance: long op, then overflow the FIFO behind it
    bus_write(1, 2'd0, 32'h0000_00A0);
    repeat (3) @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) bus_write(1, 2'd0, 32'(8'hA0 + i));
    bus_read(1, 2'd2, d);
    check("ovf_status", d, 32'h0000_080B);
    bus_write(1, 2'd2, 32'h0000_0008);
    bus_read(1, 2'd2, d);
    check("ovf_cleared", d, 32'h0000_0803);
    repeat (200) @(posedge clk); #1;
    bus_read(1, 2'd2, d);
    check("ovf_drained", d, 32'h0000_0004);
    check("ovf_op_count", 32'(n_ops[1]), 32'd9);
    check("ovf_first_queued", 32'(recs[1][1].data), 32'h0000_00A1);
    check("ovf_last_kept", 32'(recs[1][8].data), 32'h0000_00A8);
    check("ovf_gap", 32'(recs[1][1].gap), 32'd1);
    check("nosh_wr_with_cs", 32'(recs[1][0].wr_at_fall), 32'd0);
    check("nosh_cs_len", 32'(recs[1][0].cs_len), 32'(B_PULSE));
    check("nosh_wr_len", 32'(recs[1][0].wr_len), 32'(B_PULSE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
